seg_scan_monitor: RTL and testbench

Parametrised N-channel hex monitor for the board-level top. It selects one of `NUM_CH` 32-bit status words (cycle count, predictor hits/misses, display data, …), either directly or in an auto-rotate mode. It captures a frame-coherent snapshot of the selected word and drives a multiplexed active-low 7-segment array with a configurable scan rate. The decimal point marks the displayed channel index. It replaces the fixed four-way priority mux and scan driver in the top.

---
 rtl/seg_scan_monitor_pkg.sv | 17 +
 rtl/seg_scan_monitor_hex.sv | 11 +
 rtl/seg_scan_monitor.sv | 129 ++++++++++++
 tb/tb_seg_scan_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_monitor_pkg.sv
// Shared constants for the multiplexed hex monitor:
// segment patterns and digit-enable polarity.
package seg_scan_monitor_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}, index = nibble value
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic DIG_ON = 1'b0;

endpackage

// File: rtl/seg_scan_monitor_hex.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
    import seg_scan_monitor_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nib];

endmodule

// File: rtl/seg_scan_monitor.sv
// N-channel hex monitor: channel select/rotation, frame-coherent
// snapshot and multiplexed active-low 7-segment scan.
module seg_scan_monitor
    import seg_scan_monitor_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int AUTO_DWELL  = 200,
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SW-1:0]            sel,
    input  logic                     auto_mode,
    input  logic                     freeze,
    output logic [NUM_DIGITS-1:0]    enable,
    output logic [7:0]               out
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(AUTO_DWELL + 1);
    localparam int PW = 4 * NUM_DIGITS;
    localparam logic [SW:0] NCH = (SW+1)'(NUM_CH);

    logic [RW-1:0]     rcnt;
    logic [DW-1:0]     dig;
    logic [FW-1:0]     fcnt;
    logic [SW-1:0]     auto_ch;
    logic [DATA_W-1:0] snap;
    logic [SW-1:0]     snap_ch;

    logic [DATA_W-1:0] ch_w [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_w[k] = ch_data[k*DATA_W +: DATA_W];
    end

    logic              tick;
    logic              last_dig;
    logic              frame;
    logic              load;
    logic              rotate;
    logic [DW-1:0]     dig_n;
    logic [SW-1:0]     sel_c;
    logic [SW-1:0]     eff_ch;
    logic [DATA_W-1:0] snap_n;
    logic [SW-1:0]     snap_ch_n;
    logic [PW-1:0]     snap_pad;
    logic [31:0]       nib_base;
    logic [3:0]        nib;
    logic [6:0]        seg;
    logic              blank;
    logic              dp_on;

    assign tick     = (rcnt == RW'(REFRESH_DIV - 1));
    assign last_dig = (dig == DW'(NUM_DIGITS - 1));
    assign frame    = tick && last_dig;
    assign dig_n    = !tick ? dig : (last_dig ? '0 : dig + 1'b1);

    assign sel_c  = ({1'b0, sel} < NCH) ? sel : '0;
    assign eff_ch = auto_mode ? auto_ch : sel_c;
    assign load   = frame && !freeze;
    assign rotate = load && auto_mode;

    // Next-snapshot path so digit 0 shows data captured on the same edge
    assign snap_n    = load ? ch_w[eff_ch] : snap;
    assign snap_ch_n = load ? eff_ch : snap_ch;

    assign snap_pad = PW'(snap_n);
    assign nib_base = 32'({dig_n, 2'b00});
    assign nib      = snap_pad[nib_base +: 4];
    assign blank    = (nib_base >= 32'(DATA_W));
    assign dp_on    = (32'(dig_n) == 32'(snap_ch_n));

    hex_to_seg7 u_hex (
        .nib (nib),
        .seg (seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            dig  <= DW'(NUM_DIGITS - 1);
        end else begin
            rcnt <= tick ? '0 : rcnt + 1'b1;
            dig  <= dig_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt    <= '0;
            auto_ch <= '0;
        end else if (rotate) begin
            if (fcnt == FW'(AUTO_DWELL - 1)) begin
                fcnt    <= '0;
                auto_ch <= (auto_ch == SW'(NUM_CH - 1)) ? '0 : auto_ch + 1'b1;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap    <= '0;
            snap_ch <= '0;
        end else begin
            snap    <= snap_n;
            snap_ch <= snap_ch_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable <= {NUM_DIGITS{~DIG_ON}};
            out    <= SEG_BLANK;
        end else if (tick) begin
            enable <= DIG_ON ? (NUM_DIGITS'(1) << dig_n)
                             : ~(NUM_DIGITS'(1) << dig_n);
            out    <= {~dp_on, blank ? SEG_BLANK[6:0] : seg};
        end
    end

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Self-checking bench for seg_scan_monitor: cycle-count based
// reference model plus hand-computed scan sequences.
module tb_seg_scan_monitor;

    localparam int NCH = 3;
    localparam int DWD = 16;
    localparam int ND  = 4;
    localparam int RD  = 4;
    localparam int AD  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*DWD-1:0] ch_data = '0;
    logic [1:0]        sel = '0;
    logic              auto_mode = 1'b0;
    logic              freeze = 1'b0;
    logic [ND-1:0]     enable;
    logic [7:0]        out;

    int checks = 0;
    int failures = 0;
    bit compare_en = 1'b0;

    seg_scan_monitor #(
        .NUM_CH      (NCH),
        .DATA_W      (DWD),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .AUTO_DWELL  (AD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_data   (ch_data),
        .sel       (sel),
        .auto_mode (auto_mode),
        .freeze    (freeze),
        .enable    (enable),
        .out       (out)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: position in the scan derives from cycles since reset release
    int         cyc = 0;
    int         m_snap = 0;
    int         m_ch = 0;
    int         m_auto = 0;
    int         m_frames = 0;
    logic [3:0] exp_en = 4'hF;
    logic [7:0] exp_out = 8'hFF;

    always @(posedge clk or negedge rst_n) begin
        int c, d, ec, ns, nch, na, nf, nibv;
        if (!rst_n) begin
            cyc      <= 0;
            m_snap   <= 0;
            m_ch     <= 0;
            m_auto   <= 0;
            m_frames <= 0;
            exp_en   <= 4'hF;
            exp_out  <= 8'hFF;
        end else begin
            c   = cyc + 1;
            ns  = m_snap;
            nch = m_ch;
            na  = m_auto;
            nf  = m_frames;
            cyc <= c;
            if (c % RD == 0) begin
                d = ((c / RD) - 1) % ND;
                if (d == 0 && !freeze) begin
                    ec  = auto_mode ? m_auto : ((int'(sel) < NCH) ? int'(sel) : 0);
                    ns  = int'(ch_data[ec*DWD +: DWD]);
                    nch = ec;
                    if (auto_mode) begin
                        nf = nf + 1;
                        if (nf == AD) begin
                            nf = 0;
                            na = (na + 1) % NCH;
                        end
                    end
                end
                nibv = (ns >> (4 * d)) & 15;
                exp_en  <= 4'(~(1 << d));
                exp_out <= {(d == nch) ? 1'b0 : 1'b1, seg_tab[nibv]};
            end
            m_snap   <= ns;
            m_ch     <= nch;
            m_auto   <= na;
            m_frames <= nf;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_en)
            chk("scan", {20'h0, enable, out}, {20'h0, exp_en, exp_out});
    end

    task automatic pin(input string nm, input logic [3:0] en,
                       input logic [7:0] o);
        chk({nm, "_en"}, 32'(enable), 32'(en));
        chk({nm, "_out"}, 32'(out), 32'(o));
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic boot_check();
        sel       = 2'd0;
        auto_mode = 1'b0;
        freeze    = 1'b0;
        ch_data   = 48'h0000_0000_1234;
        @(negedge clk);
        rst_n = 1'b1;
        skip(3); pin("blank", 4'hF, 8'hFF);
        skip(1); pin("d0", 4'b1110, 8'h19);
        skip(4); pin("d1", 4'b1101, 8'hB0);
        skip(4); pin("d2", 4'b1011, 8'hA4);
        skip(4); pin("d3", 4'b0111, 8'hF9);
        skip(4); pin("d0_again", 4'b1110, 8'h19);
    endtask

    logic [7:0] auto_seq [7] = '{8'h40, 8'h40, 8'hF9, 8'hF9, 8'hA4, 8'hA4, 8'h40};

    initial begin
        skip(2);
        compare_en = 1'b1;
        boot_check();

        // Mid-frame select change takes effect at the next frame edge
        ch_data[2*DWD +: DWD] = 16'hABCD;
        sel = 2'd2;
        skip(4); pin("hold_d1", 4'b1101, 8'hB0);
        skip(4); pin("hold_d2", 4'b1011, 8'hA4);
        skip(4); pin("hold_d3", 4'b0111, 8'hF9);
        skip(4); pin("ch2_d0", 4'b1110, 8'hA1);
        skip(4); pin("ch2_d1", 4'b1101, 8'hC6);
        skip(4); pin("ch2_d2", 4'b1011, 8'h03);
        skip(4); pin("ch2_d3", 4'b0111, 8'h88);

        sel = 2'd3;
        skip(4); pin("sel_oor", 4'b1110, 8'h19);

        ch_data   = {16'h1232, 16'h1231, 16'h1230};
        auto_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            skip(16);
            pin($sformatf("auto%0d", i), 4'b1110, auto_seq[i]);
        end

        freeze = 1'b1;
        ch_data[DWD-1:0] = 16'h5555;
        skip(16); pin("frz0", 4'b1110, 8'h40);
        skip(16); pin("frz1", 4'b1110, 8'h40);
        freeze = 1'b0;
        skip(16); pin("unfrz0", 4'b1110, 8'h12);
        skip(16); pin("unfrz1", 4'b1110, 8'hF9);

        // Asynchronous reset in the middle of a slot
        skip(2);
        #2 rst_n = 1'b0;
        #1 pin("async_rst", 4'hF, 8'hFF);
        boot_check();

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                ch_data = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0)
                sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0)
                auto_mode = ~auto_mode;
            if ($urandom_range(0, 47) == 0)
                freeze = ~freeze;
        end

        skip(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
